// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encodings, parity modes, oversampling
// constants and the layout of one received FIFO entry.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      STRT = 3'd1,
      DATA = 3'd2,
      PRTY = 3'd3,
      STOP = 3'd4,
      BRKW = 3'd5
   } rx_state_e;

   localparam int PAR_NONE = 0;
   localparam int PAR_ODD  = 1;
   localparam int PAR_EVEN = 2;

   localparam int         OVERSAMPLE = 16;
   localparam logic [3:0] S_LAST     = 4'(OVERSAMPLE - 1);
   localparam logic [3:0] VOTE0      = 4'd7;
   localparam logic [3:0] VOTE1      = 4'd8;
   localparam logic [3:0] VOTE2      = 4'd9;

   localparam int ENTRY_W = 10;

   typedef struct packed {
      logic       parity_err;
      logic       frame_err;
      logic [7:0] data;
   } rx_entry_t;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_rx_buffered_if.sv
// Consumer-side bundle of the buffered UART receiver.
// Handshake: RXVALID means the head entry is presented; it is consumed on any
// CLOCK edge where RXVALID and RXREADY are both high. RXREADY with RXVALID low
// has no effect.
interface uart_rx_buffered_if #(parameter int FIFODEPTH = 8);
   import uart_pkg::*;

   logic                               RXREADY;
   logic [7:0]                         RXDATA;
   logic                               RXVALID;
   logic                               FRAMEERR;
   logic                               PARITYERR;
   logic                               OVERRUN;
   logic                               BREAK;
   logic [$clog2(FIFODEPTH+1)-1:0]     FIFOCOUNT;
   rx_state_e                          dbg_state;

   modport master (
      input  RXREADY,
      output RXDATA, RXVALID, FRAMEERR, PARITYERR, OVERRUN, BREAK, FIFOCOUNT, dbg_state
   );

   modport slave (
      output RXREADY,
      input  RXDATA, RXVALID, FRAMEERR, PARITYERR, OVERRUN, BREAK, FIFOCOUNT, dbg_state
   );
endinterface

// File: rtl/uart_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; the head word is visible on dout
// whenever the FIFO is non-empty and reads as zero when empty.
module uart_sync_fifo #(
   parameter  int WIDTH = 10,
   parameter  int DEPTH = 8,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;
   assign dout  = empty ? '0 : mem_q[rd_q];

   // A pop frees the slot in the same edge, so a full FIFO still accepts a push.
   assign do_push = push & (~full | pop);
   assign do_pop  = pop & ~empty;

   always_comb begin
      wr_d    = wr_q;
      rd_d    = rd_q;
      count_d = count_q;
      if (do_push) wr_d = wr_q + 1'b1;
      if (do_pop)  rd_d = rd_q + 1'b1;
      if (do_push && !do_pop)      count_d = count_q + 1'b1;
      else if (do_pop && !do_push) count_d = count_q - 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else begin
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= din;
   end
endmodule

// File: rtl/uart_rx_buffered.sv
// UART receiver with 16x oversampling, 3-vote majority per bit, optional parity,
// framing/break detection, and a FWFT result FIFO drained by valid/ready.
module uart_rx_buffered
   import uart_pkg::*;
#(
   parameter int PARITY    = 0,
   parameter int FIFODEPTH = 8,
   parameter int DATABITS  = 8
) (
   input  logic               CLOCK,
   input  logic               RESETN,
   input  logic               RX,
   input  logic               STICK,
   uart_rx_buffered_if.master rxo
);
   if (DATABITS != 8) begin : g_bad_databits
      $error("uart_rx_buffered: DATABITS must be 8");
   end
   if (FIFODEPTH < 2 || (FIFODEPTH & (FIFODEPTH - 1)) != 0) begin : g_bad_depth
      $error("uart_rx_buffered: FIFODEPTH must be a power of two >= 2");
   end
   if (PARITY != PAR_NONE && PARITY != PAR_ODD && PARITY != PAR_EVEN) begin : g_bad_parity
      $error("uart_rx_buffered: PARITY must be 0, 1 or 2");
   end

   logic       rx_meta_q, rxs_q, rxp_q, rxp_d;
   rx_state_e  state_q, state_d;
   logic [3:0] s_q, s_d;
   logic [2:0] n_q, n_d;
   logic [1:0] vote_q, vote_d;
   logic [7:0] data_q, data_d;
   logic       pbit_q, pbit_d, perr_q, perr_d;
   logic       brk_q, brk_d, ovr_q, ovr_d;
   logic       maj, push, fifo_full, fifo_empty;
   rx_entry_t  push_entry, head;

   // The third vote is the live sample, so the bit decision lands on S=9 itself.
   assign maj = maj3(vote_q[0], vote_q[1], rxs_q);

   always_comb begin
      state_d    = state_q;
      s_d        = s_q;
      n_d        = n_q;
      vote_d     = vote_q;
      data_d     = data_q;
      pbit_d     = pbit_q;
      perr_d     = perr_q;
      rxp_d      = rxp_q;
      brk_d      = 1'b0;
      push       = 1'b0;
      push_entry = '{parity_err: perr_q, frame_err: ~maj, data: data_q};
      if (STICK) begin
         rxp_d = rxs_q;
         if (state_q != IDLE) s_d = s_q + 4'd1;
         if (s_q == VOTE0) vote_d[0] = rxs_q;
         if (s_q == VOTE1) vote_d[1] = rxs_q;
         case (state_q)
            IDLE: if (rxp_q && !rxs_q) begin
               state_d = STRT;
               s_d     = '0;
               n_d     = '0;
               pbit_d  = 1'b0;
               perr_d  = 1'b0;
            end
            STRT: begin
               if (s_q == VOTE2 && maj) state_d = IDLE;
               else if (s_q == S_LAST)  state_d = DATA;
            end
            DATA: begin
               if (s_q == VOTE2) data_d = {maj, data_q[7:1]};
               if (s_q == S_LAST) begin
                  if (n_q == 3'd7) state_d = (PARITY != PAR_NONE) ? PRTY : STOP;
                  else             n_d     = n_q + 3'd1;
               end
            end
            PRTY: begin
               if (s_q == VOTE2) begin
                  pbit_d = maj;
                  perr_d = (PARITY == PAR_EVEN) ? (^data_q ^ maj) : ~(^data_q ^ maj);
               end
               if (s_q == S_LAST) state_d = STOP;
            end
            // Finishing at S=9 leaves half a stop bit to catch a back-to-back start edge.
            STOP: if (s_q == VOTE2) begin
               if (data_q == 8'h00 && !pbit_q && !maj) begin
                  brk_d   = 1'b1;
                  state_d = BRKW;
               end else begin
                  push    = 1'b1;
                  state_d = IDLE;
               end
            end
            BRKW: if (rxs_q) state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
      ovr_d = push & fifo_full & ~rxo.RXREADY;
   end

   always_ff @(posedge CLOCK or negedge RESETN) begin
      if (!RESETN) begin
         rx_meta_q <= 1'b1;
         rxs_q     <= 1'b1;
         rxp_q     <= 1'b1;
         state_q   <= IDLE;
         s_q       <= '0;
         n_q       <= '0;
         vote_q    <= '0;
         data_q    <= '0;
         pbit_q    <= 1'b0;
         perr_q    <= 1'b0;
         brk_q     <= 1'b0;
         ovr_q     <= 1'b0;
      end else begin
         rx_meta_q <= RX;
         rxs_q     <= rx_meta_q;
         rxp_q     <= rxp_d;
         state_q   <= state_d;
         s_q       <= s_d;
         n_q       <= n_d;
         vote_q    <= vote_d;
         data_q    <= data_d;
         pbit_q    <= pbit_d;
         perr_q    <= perr_d;
         brk_q     <= brk_d;
         ovr_q     <= ovr_d;
      end
   end

   uart_sync_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFODEPTH)) u_fifo (
      .clk   (CLOCK),
      .rst_n (RESETN),
      .push  (push),
      .din   (push_entry),
      .pop   (rxo.RXREADY),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (rxo.FIFOCOUNT)
   );

   assign rxo.RXDATA    = head.data;
   assign rxo.FRAMEERR  = head.frame_err;
   assign rxo.PARITYERR = head.parity_err;
   assign rxo.RXVALID   = ~fifo_empty;
   assign rxo.OVERRUN   = ovr_q;
   assign rxo.BREAK     = brk_q;
   assign rxo.dbg_state = state_q;
endmodule

// File: tb/tb_uart_rx_buffered.sv
// Directed bench for uart_rx_buffered: an 8N1 instance and an even-parity
// instance share clock, tick and reset; each has its own RX line.
module tb_uart_rx_buffered;
   import uart_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n, stick, rx_n, rx_e;

   uart_rx_buffered_if #(.FIFODEPTH(8)) if_n ();
   uart_rx_buffered_if #(.FIFODEPTH(8)) if_e ();

   uart_rx_buffered #(.PARITY(0), .FIFODEPTH(8), .DATABITS(8)) u_dut_n (
      .CLOCK(clk), .RESETN(rst_n), .RX(rx_n), .STICK(stick), .rxo(if_n.master));
   uart_rx_buffered #(.PARITY(2), .FIFODEPTH(8), .DATABITS(8)) u_dut_e (
      .CLOCK(clk), .RESETN(rst_n), .RX(rx_e), .STICK(stick), .rxo(if_e.master));

   typedef struct {
      logic       sel;       // 0: 8N1 instance, 1: even-parity instance
      logic [7:0] data;
      logic       has_par;
      logic       pbit;
      logic       stop;
      int         glitch;    // data bit index carrying a one-tick glitch, -1 none
      logic [7:0] exp_data;
      logic       exp_ferr;
      logic       exp_perr;
   } vec_t;

   typedef struct {
      logic       valid;
      logic [7:0] data;
      logic       ferr;
      logic       perr;
      logic [3:0] count;
   } out_t;

   vec_t       vecs[8];
   logic [7:0] exp_q[$];
   int         n_tests = 0;
   int         n_fail  = 0;
   int         brk_n   = 0;
   int         ovr_n   = 0;
   int         base;

   always @(negedge clk) begin
      if (if_n.BREAK)   brk_n++;
      if (if_n.OVERRUN) ovr_n++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic out_t sample(input logic sel);
      out_t o;
      if (sel) begin
         o.valid = if_e.RXVALID; o.data = if_e.RXDATA; o.ferr = if_e.FRAMEERR;
         o.perr  = if_e.PARITYERR; o.count = if_e.FIFOCOUNT;
      end else begin
         o.valid = if_n.RXVALID; o.data = if_n.RXDATA; o.ferr = if_n.FRAMEERR;
         o.perr  = if_n.PARITYERR; o.count = if_n.FIFOCOUNT;
      end
      return o;
   endfunction

   // One STICK period of four clocks; returns on the negedge just after the tick edge.
   task automatic tick();
      repeat (3) @(negedge clk);
      stick = 1'b1;
      @(negedge clk);
      stick = 1'b0;
   endtask

   task automatic tick_pop();
      repeat (3) @(negedge clk);
      stick        = 1'b1;
      if_n.RXREADY = 1'b1;
      @(negedge clk);
      stick        = 1'b0;
      if_n.RXREADY = 1'b0;
   endtask

   task automatic drive_bit(input logic sel, input logic v, input int n);
      if (sel) rx_e = v; else rx_n = v;
      repeat (n) tick();
   endtask

   task automatic pop(input logic sel);
      @(negedge clk);
      if (sel) if_e.RXREADY = 1'b1; else if_n.RXREADY = 1'b1;
      @(negedge clk);
      if_e.RXREADY = 1'b0;
      if_n.RXREADY = 1'b0;
   endtask

   // Drives a frame up to, but not including, the stop-bit tick that completes it.
   task automatic send_frame(input logic sel, input logic [7:0] d, input logic has_par,
                             input logic pbit, input logic stop, input int glitch);
      drive_bit(sel, 1'b0, 16);
      for (int i = 0; i < 8; i++) begin
         if (i == glitch) begin
            drive_bit(sel, d[i], 9);
            drive_bit(sel, ~d[i], 1);
            drive_bit(sel, d[i], 6);
         end else begin
            drive_bit(sel, d[i], 16);
         end
      end
      if (has_par) drive_bit(sel, pbit, 16);
      drive_bit(sel, stop, 10);
   endtask

   task automatic run_vec(input vec_t v);
      out_t o;
      send_frame(v.sel, v.data, v.has_par, v.pbit, v.stop, v.glitch);
      o = sample(v.sel);
      check("valid_before_stop", o.valid, 1'b0);
      tick();
      o = sample(v.sel);
      check("valid_after_stop", o.valid, 1'b1);
      check("rxdata", o.data, v.exp_data);
      check("frameerr", o.ferr, v.exp_ferr);
      check("parityerr", o.perr, v.exp_perr);
      check("fifocount", o.count, 4'd1);
      drive_bit(v.sel, 1'b1, 5);
      pop(v.sel);
      o = sample(v.sel);
      check("valid_after_pop", o.valid, 1'b0);
   endtask

   task automatic send_plain_n(input logic [7:0] d);
      send_frame(1'b0, d, 1'b0, 1'b0, 1'b1, -1);
      tick();
      drive_bit(1'b0, 1'b1, 5);
   endtask

   initial begin
      //                sel   data   par   pbit  stop  gl  exp    ferr  perr
      vecs[0] = '{1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, -1, 8'hA5, 1'b0, 1'b0};
      vecs[1] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1,  3, 8'h00, 1'b0, 1'b0};
      vecs[2] = '{1'b1, 8'h3C, 1'b1, 1'b1, 1'b1, -1, 8'h3C, 1'b0, 1'b1};
      vecs[3] = '{1'b1, 8'h3C, 1'b1, 1'b0, 1'b1, -1, 8'h3C, 1'b0, 1'b0};
      vecs[4] = '{1'b0, 8'h55, 1'b0, 1'b0, 1'b0, -1, 8'h55, 1'b1, 1'b0};
      vecs[5] = '{1'b0, 8'h12, 1'b0, 1'b0, 1'b1, -1, 8'h12, 1'b0, 1'b0};
      vecs[6] = '{1'b1, 8'h01, 1'b1, 1'b1, 1'b1, -1, 8'h01, 1'b0, 1'b0};
      vecs[7] = '{1'b1, 8'h80, 1'b1, 1'b0, 1'b0, -1, 8'h80, 1'b1, 1'b1};

      rst_n = 1'b0; stick = 1'b0; rx_n = 1'b1; rx_e = 1'b1;
      if_n.RXREADY = 1'b0; if_e.RXREADY = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_rxvalid", if_n.RXVALID, 1'b0);
      check("reset_rxdata", if_n.RXDATA, 8'h00);
      check("reset_fifocount", if_n.FIFOCOUNT, 4'd0);
      check("reset_state", if_n.dbg_state, IDLE);
      rst_n = 1'b1;
      drive_bit(1'b0, 1'b1, 4);

      for (int i = 0; i < 8; i++) run_vec(vecs[i]);

      // Short low pulse on the line must be rejected as a false start.
      base = brk_n;
      drive_bit(1'b0, 1'b0, 4);
      drive_bit(1'b0, 1'b1, 20);
      check("false_start_state", if_n.dbg_state, IDLE);
      check("false_start_valid", if_n.RXVALID, 1'b0);
      check("false_start_break", brk_n - base, 0);

      // Line held low for 20 bit times: one break, nothing pushed, then a clean frame.
      base = brk_n;
      drive_bit(1'b0, 1'b0, 320);
      drive_bit(1'b0, 1'b1, 16);
      check("break_pulses", brk_n - base, 1);
      check("break_count", if_n.FIFOCOUNT, 4'd0);
      check("break_state", if_n.dbg_state, IDLE);
      run_vec(vecs[5]);

      // Nine frames into an eight-entry FIFO with no consumer.
      base = ovr_n;
      for (int i = 1; i <= 9; i++) begin
         send_plain_n(8'(i));
         if (exp_q.size() < 8) exp_q.push_back(8'(i));
         check("overrun_pulses", ovr_n - base, (i == 9) ? 1 : 0);
      end
      check("overrun_count", if_n.FIFOCOUNT, 4'd8);
      for (int k = 0; k < 8; k++) begin
         check("drain_valid", if_n.RXVALID, 1'b1);
         check("drain_data", if_n.RXDATA, exp_q.pop_front());
         pop(1'b0);
      end
      check("drain_empty", if_n.RXVALID, 1'b0);
      check("drain_count", if_n.FIFOCOUNT, 4'd0);

      // Full FIFO, pop coinciding with the completing push.
      for (int i = 0; i < 8; i++) begin
         send_plain_n(8'h20 + 8'(i));
         exp_q.push_back(8'h20 + 8'(i));
      end
      base = ovr_n;
      send_frame(1'b0, 8'h28, 1'b0, 1'b0, 1'b1, -1);
      tick_pop();
      void'(exp_q.pop_front());
      exp_q.push_back(8'h28);
      drive_bit(1'b0, 1'b1, 5);
      check("pushpop_count", if_n.FIFOCOUNT, 4'd8);
      check("pushpop_overrun", ovr_n - base, 0);
      check("pushpop_head", if_n.RXDATA, exp_q[0]);

      // Reset in the middle of a frame while the FIFO is full.
      drive_bit(1'b0, 1'b0, 16);
      drive_bit(1'b0, 1'b0, 16);
      drive_bit(1'b0, 1'b1, 16);
      drive_bit(1'b0, 1'b1, 7);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      exp_q.delete();
      check("midrst_rxvalid", if_n.RXVALID, 1'b0);
      check("midrst_rxdata", if_n.RXDATA, 8'h00);
      check("midrst_frameerr", if_n.FRAMEERR, 1'b0);
      check("midrst_parityerr", if_n.PARITYERR, 1'b0);
      check("midrst_overrun", if_n.OVERRUN, 1'b0);
      check("midrst_break", if_n.BREAK, 1'b0);
      check("midrst_count", if_n.FIFOCOUNT, 4'd0);
      check("midrst_state", if_n.dbg_state, IDLE);
      rx_n = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      drive_bit(1'b0, 1'b1, 16);
      vecs[0] = '{1'b0, 8'h7E, 1'b0, 1'b0, 1'b1, -1, 8'h7E, 1'b0, 1'b0};
      run_vec(vecs[0]);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/uart_rx_buffered.md
Name: uart_rx_buffered

Overview:
Robust UART receiver, the companion to the existing Transmitter.
- Front end: input synchroniser, 16x oversampling with 3-sample majority vote, false-start rejection.
- Frame checks: optional parity, framing-error and break detection.
- Output: received bytes and their error flags go into a small first-word-fall-through FIFO drained by a valid/ready handshake.
- Sits between the RX pad and the processor's I/O register block; the tick comes from the baud tick generator.

Parameters:
PARITY, 0, parity mode: 0 none, 1 odd, 2 even
FIFODEPTH, 8, FIFO entries; power of two, >= 2
DATABITS, 8, data bits per frame; fixed at 8 and checked at elaboration

Ports:
CLOCK  input  1  system clock
RESETN  input  1  asynchronous active-low reset
RX  input  1  serial line, asynchronous, idle high
STICK  input  1  one-CLOCK-wide pulse at 16x baud
RXREADY  input  1  consumer accepts head entry
RXDATA  output  8  head-of-FIFO byte
RXVALID  output  1  FIFO not empty
FRAMEERR  output  1  head entry had stop bit sampled 0
PARITYERR  output  1  head entry failed parity (always 0 when PARITY=0)
OVERRUN  output  1  one-cycle pulse: frame dropped, FIFO full
BREAK  output  1  one-cycle pulse: break condition detected
FIFOCOUNT  output  clog2(FIFODEPTH+1)  entries held

Behaviour:
Reset (RESETN low):
- State IDLE; FIFO empty.
- Synchroniser flops set to 1, so there is no false start on release.
- Output reset values: RXDATA=0, RXVALID=0, FRAMEERR=0, PARITYERR=0, OVERRUN=0, BREAK=0, FIFOCOUNT=0.
- Reset mid-frame abandons the frame; the partial byte is discarded.

Input path:
- RX goes through a 2-flop synchroniser (RXS).
- All sampling acts only on CLOCK edges where STICK=1.
- Tick counter S (4 bits) counts 0..15 per bit period.

Sampling:
- In every bit period the votes are taken at S=7, 8, 9.
- Bit value = majority of the 3 votes.

States:
- IDLE: falling edge of RXS -> STRT, S=0.
- STRT: vote at S=7..9.
  - Majority 1 -> IDLE (glitch rejected, nothing pushed).
  - Otherwise, at S=15 -> DATA, S=0, bit index N=0.
- DATA: majority bit shifted in LSB first.
  - At S=15 with N=7 -> PRTY if PARITY!=0, else STOP.
  - Otherwise N+1, S=0.
- PRTY: majority compared against the computed parity.
  - Odd mode: XOR of data and parity bit must be 1.
  - Even mode: the same XOR must be 0.
  - At S=15 -> STOP.
- STOP: frame completes at S=9, not S=15, so a back-to-back start edge is not missed.
  - Break = data all 0, parity bit 0 (if present), stop 0. Pulse BREAK, push nothing, -> BRKW.
  - Otherwise push {PARITYERR, FRAMEERR, byte}, where FRAMEERR = stop majority 0, and -> IDLE.
- BRKW: wait for RXS=1 on a STICK cycle -> IDLE.

FIFO:
- Storage is registered; head is shown first-word-fall-through.
- RXDATA, FRAMEERR and PARITYERR always describe the head entry; they are 0 when empty.
- Pop happens on a CLOCK edge with RXVALID & RXREADY.
- Push happens on the CLOCK edge of the completing STICK. RXVALID rises the following cycle if the FIFO was empty.
- Full and push, no pop: the new entry is dropped and OVERRUN pulses for 1 cycle. Existing contents are unchanged.
- Full, push and pop in the same cycle: both happen; count unchanged; no OVERRUN.
- Empty and pop request: ignored (RXVALID=0).
- Pointers wrap modulo FIFODEPTH. FIFOCOUNT ranges 0..FIFODEPTH.

Decomposition:
- Shared package uart_pkg holds:
  - state encodings IDLE/STRT/DATA/PRTY/STOP/BRKW (3-bit);
  - parity mode constants PAR_NONE/PAR_ODD/PAR_EVEN;
  - OVERSAMPLE=16 and the vote positions 7/8/9;
  - the 10-bit entry layout.
- One sub-module, uart_sync_fifo: parameterised width and depth, FWFT, push/pop/full/empty/count. It is reusable for the transmit side later.

Test Plan:
1. 8N1, send 0xA5 with 16 ticks per bit, RXREADY=0 -> RXVALID=1 one cycle after the stop-bit S=9 tick; RXDATA=0xA5; FRAMEERR=0; FIFOCOUNT=1.
2. RX low for 4 ticks then high -> stays IDLE; RXVALID=0; no flags. Then a 1-tick glitch during data bit 3 of 0x00 -> still received as 0x00 (majority vote).
3. PARITY=2, send 0x3C with parity bit 1 -> RXDATA=0x3C, PARITYERR=1. Then 0x3C with parity bit 0 -> PARITYERR=0.
4. 8N1, send 0x55 with stop bit 0 -> pushed with FRAMEERR=1. Then hold RX low for 20 bit times -> exactly one BREAK pulse; nothing pushed; a following 0x12 frame is received correctly once RX has returned high.
5. FIFODEPTH=8, RXREADY=0, send 0x01..0x09 -> FIFOCOUNT=8, one OVERRUN pulse on the 9th frame. Draining yields 0x01..0x08 in order, then RXVALID=0.
6. FIFO full, RXREADY held high so a pop coincides with a push -> count stays 8, no OVERRUN. Then assert RESETN low mid-frame -> all outputs 0; next clean frame 0x7E is received correctly.
